// File: rtl/fifo_burst_relay_if.sv
// Relay-to-FIFO bundle: rx FIFO head/flags/pop strobe and tx FIFO full flag/write port.
// The relay takes the master modport; the FIFO side (or a bench) takes the slave modport.
interface fifo_burst_relay_if #(
  parameter int DATA_W = 8
);
  logic              src_full;
  logic              src_empty;
  logic [DATA_W-1:0] src_data;
  logic              src_rd;
  logic              dst_full;
  logic [DATA_W-1:0] dst_data;
  logic              dst_wr;

  modport master (
    input  src_full, src_empty, src_data, dst_full,
    output src_rd, dst_data, dst_wr
  );

  modport slave (
    output src_full, src_empty, src_data, dst_full,
    input  src_rd, dst_data, dst_wr
  );
endinterface

// File: rtl/fifo_burst_relay.sv
// Burst-drains the rx FIFO into the tx FIFO, one byte per READ/WRITE cycle pair, stalling in WRITE on dst_full.
// FIFO_RELAY_INVERT_EN: relay the bitwise complement of each byte instead of the byte itself.
module fifo_burst_relay #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  fifo_burst_relay_if.master fifo,
  output logic               busy,
  output logic               burst_done,
  output logic [CNT_W-1:0]   burst_count
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] data_out;
  logic              burst_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Empty is only checked in READ, so bytes landing mid-burst join the same burst.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if ((fifo.src_full | start) & !fifo.src_empty) state_nxt = READ;
      READ:    state_nxt = fifo.src_empty ? DONE : WRITE;
      WRITE:   if (!fifo.dst_full) state_nxt = READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FIFO_RELAY_INVERT_EN
  assign data_out = ~data_reg;
`else
  assign data_out = data_reg;
`endif

  always_comb begin
    fifo.src_rd   = 1'b0;
    fifo.dst_wr   = 1'b0;
    fifo.dst_data = '0;
    busy          = (state != IDLE);
    burst_done    = (state == DONE);
    case (state)
      READ:  fifo.src_rd = !fifo.src_empty;
      WRITE: begin
        if (!fifo.dst_full) begin
          fifo.dst_wr   = 1'b1;
          fifo.dst_data = data_out;
        end
      end
      default: ;
    endcase
  end

  assign burst_start = (state == IDLE) && (state_nxt == READ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg    <= '0;
      burst_count <= '0;
    end else begin
      if (fifo.src_rd) data_reg <= fifo.src_data;
      if (burst_start)      burst_count <= '0;
      else if (fifo.dst_wr) burst_count <= burst_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_burst_relay.sv
// Bench for fifo_burst_relay: queue-modelled 4-deep rx FIFO, tx write capture, directed scenarios then random traffic.
// Relayed bytes are scoreboarded against everything pushed into the rx FIFO, in push order.
module tb_fifo_burst_relay;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy;
  logic             burst_done;
  logic [CNT_W-1:0] burst_count;

  fifo_burst_relay_if #(.DATA_W(DATA_W)) bus ();

  fifo_burst_relay #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .fifo        (bus),
    .busy        (busy),
    .burst_done  (burst_done),
    .burst_count (burst_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] srcq[$];
  logic [7:0] expq[$];
  logic [7:0] gotq[$];
  int rd_cyc[$];
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cnt = 0, wr_in_burst = 0, done_cyc = 0;

  function automatic logic [7:0] relay_f(input logic [7:0] x);
`ifdef FIFO_RELAY_INVERT_EN
    return 8'hFF - x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_src();
    bus.src_empty = (srcq.size() == 0);
    bus.src_full  = (srcq.size() >= DEPTH);
    bus.src_data  = (srcq.size() > 0) ? srcq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    srcq.push_back(b);
    expq.push_back(relay_f(b));
    drive_src();
  endtask

  // One clock: observe at negedge, then update the FIFO model just after the rising edge.
  task automatic step();
    logic rd, wr;
    @(negedge clk);
    rd = bus.src_rd;
    wr = bus.dst_wr;
    chk("rd_wr_exclusive", {31'b0, rd & wr}, 0);
    if (!wr) chk("dst_data_idle", {24'b0, bus.dst_data}, 0);
    if (rd) begin rd_cnt++; rd_cyc.push_back(cyc); end
    if (wr) begin wr_cnt++; wr_in_burst++; gotq.push_back(bus.dst_data); end
    if (busy) busy_cnt++;
    if (burst_done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("burst_count_at_done", {16'b0, burst_count}, wr_in_burst);
      wr_in_burst = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd && srcq.size() > 0) srcq.delete(0);
    start = 1'b0;
    drive_src();
  endtask

  task automatic run_burst(input int budget);
    int d0 = done_cnt;
    int k  = 0;
    while (done_cnt == d0 && k < budget) begin step(); k++; end
    chk("burst_end_seen", done_cnt - d0, 1);
    step();
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_len"}, gotq.size(), expq.size());
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) chk({tag, "_dat"}, {24'b0, gotq[i]}, {24'b0, expq[i]});
    gotq.delete();
    expq.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_src_rd"}, {31'b0, bus.src_rd}, 0);
    chk({tag, "_dst_wr"}, {31'b0, bus.dst_wr}, 0);
    chk({tag, "_dst_data"}, {24'b0, bus.dst_data}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_burst_done"}, {31'b0, burst_done}, 0);
    chk({tag, "_burst_count"}, {16'b0, burst_count}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat[4];
    int t0, r0, w0, b0, d0, k;
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};

    reset = 1'b1; start = 1'b0; bus.dst_full = 1'b0; drive_src();
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Full-triggered 4-byte burst, no back-pressure.
    foreach (pat[i]) push(pat[i]);
    t0 = cyc; r0 = rd_cnt; rd_cyc.delete();
    run_burst(40);
    chk("full_rd_count", rd_cnt - r0, 4);
    if (rd_cyc.size() > 0) chk("full_first_rd", rd_cyc[0] - t0, 1);
    for (int i = 1; i < rd_cyc.size(); i++) chk("full_rd_gap", rd_cyc[i] - rd_cyc[i-1], 2);
    if (rd_cyc.size() > 0) chk("full_done_latency", done_cyc - rd_cyc[rd_cyc.size()-1], 3);
    chk("full_count", {16'b0, burst_count}, 4);
    chk("full_busy_after", {31'b0, busy}, 0);
    compare_stream("full");

    // Back-pressure for 5 cycles right after the first pop.
    foreach (pat[i]) push(pat[i]);
    r0 = rd_cnt; w0 = wr_cnt;
    step(); step();
    chk("bp_first_pop", rd_cnt - r0, 1);
    bus.dst_full = 1'b1;
    repeat (5) step();
    chk("bp_no_wr", wr_cnt - w0, 0);
    chk("bp_no_second_rd", rd_cnt - r0, 1);
    chk("bp_data_reg", {24'b0, dut.data_reg}, 32'h11);
    bus.dst_full = 1'b0;
    run_burst(40);
    chk("bp_count", {16'b0, burst_count}, 4);
    compare_stream("bp");

    // Manual start with 2 bytes, then a start on an empty FIFO.
    push(8'h5A); push(8'hA5);
    start = 1'b1;
    run_burst(30);
    chk("start_count", {16'b0, burst_count}, 2);
    compare_stream("start");
    b0 = busy_cnt; r0 = rd_cnt;
    start = 1'b1;
    repeat (5) step();
    chk("start_empty_busy", busy_cnt - b0, 0);
    chk("start_empty_rd", rd_cnt - r0, 0);

    // Refill while the last byte is in WRITE.
    foreach (pat[i]) push(pat[i]);
    r0 = rd_cnt; d0 = done_cnt; k = 0;
    while (rd_cnt - r0 < 4 && k < 40) begin step(); k++; end
    chk("refill_reached_last", rd_cnt - r0, 4);
    push(8'h55);
    run_burst(40);
    chk("refill_count", {16'b0, burst_count}, 5);
    chk("refill_single_done", done_cnt - d0, 1);
    compare_stream("refill");

    // Start pulsed mid-burst is neither honoured nor queued.
    push(8'h01); push(8'h02); push(8'h03);
    start = 1'b1; d0 = done_cnt;
    repeat (3) step();
    start = 1'b1;
    run_burst(40);
    compare_stream("busy_trig");
    push(8'h77);
    r0 = rd_cnt;
    repeat (6) step();
    chk("busy_trig_no_rd", rd_cnt - r0, 0);
    chk("busy_trig_one_done", done_cnt - d0, 1);
    srcq.delete(); expq.delete(); drive_src();

    // Reset asserted mid-WRITE with 3 bytes left in src.
    foreach (pat[i]) push(pat[i]);
    step(); step();
    chk("pre_reset_wr", {31'b0, bus.dst_wr}, 1);
    chk("pre_reset_busy", {31'b0, busy}, 1);
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    r0 = rd_cnt; b0 = busy_cnt;
    repeat (3) step();
    chk("post_reset_idle_busy", busy_cnt - b0, 0);
    chk("post_reset_idle_rd", rd_cnt - r0, 0);
    srcq.delete(); expq.delete(); gotq.delete(); wr_in_burst = 0; drive_src();

    // Random traffic, back-pressure and start pulses.
    for (int n = 0; n < 3000; n++) begin
      if (srcq.size() < DEPTH && $urandom_range(0, 2) == 0) push(8'($urandom_range(0, 255)));
      bus.dst_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 30) == 0) start = 1'b1;
      step();
    end
    bus.dst_full = 1'b0;
    k = 0;
    while ((srcq.size() > 0 || busy) && k < 200) begin
      if (!busy) start = 1'b1;
      step();
      k++;
    end
    chk("rand_drained", srcq.size(), 0);
    compare_stream("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
